// File: rtl/sc_gauss_blur_acc.sv
// Stochastic 3x3 Gaussian blur for NOUT adjacent pixels: one LFSR-driven weighted tap select per beat,
// z_bits one cycle after each accepted beat, frame counts after STREAM_LEN beats; in_valid low stalls, result held until out_ready.
module sc_gauss_blur_acc #(
    parameter int         NOUT       = 2,
    parameter int         STREAM_LEN = 256,
    parameter logic [7:0] SEED       = 8'h5A,
    localparam int        CW         = $clog2(STREAM_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3*(NOUT+2)-1:0]   pix_bits,
    output logic [NOUT-1:0]         z_bits,
    output logic                    z_valid,
    output logic [NOUT*CW-1:0]      out_count,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam int W = NOUT + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [CW-1:0]      beat_q, beat_d;
    logic [NOUT*CW-1:0] cnt_q, cnt_d;
    logic [NOUT-1:0]    z_bits_q, z_bits_d;
    logic               z_valid_q, z_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [NOUT-1:0]    sel_bits;
    logic               accept;

    // Kernel weights 1/2/4 out of 16 come from how many select codes map to each tap.
    always_comb begin
        sel_bits = '0;
        for (int k = 0; k < NOUT; k++) begin
            case (lfsr_q[3:0])
                4'd0:        sel_bits[k] = pix_bits[k];
                4'd1:        sel_bits[k] = pix_bits[k + 2];
                4'd2:        sel_bits[k] = pix_bits[2*W + k];
                4'd3:        sel_bits[k] = pix_bits[2*W + k + 2];
                4'd4, 4'd5:  sel_bits[k] = pix_bits[k + 1];
                4'd6, 4'd7:  sel_bits[k] = pix_bits[W + k];
                4'd8, 4'd9:  sel_bits[k] = pix_bits[W + k + 2];
                4'd10, 4'd11: sel_bits[k] = pix_bits[2*W + k + 1];
                default:     sel_bits[k] = pix_bits[W + k + 1];
            endcase
        end
    end

    always_comb begin
        accept    = in_valid && in_ready_q;
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        beat_d    = beat_q;
        cnt_d     = cnt_q;
        z_bits_d  = z_bits_q;
        z_valid_d = accept;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    lfsr_d  = SEED;
                    beat_d  = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    lfsr_d   = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
                    beat_d   = beat_q + CW'(1);
                    z_bits_d = sel_bits;
                    for (int k = 0; k < NOUT; k++) begin
                        if (sel_bits[k] && (cnt_q[k*CW +: CW] != CW'(STREAM_LEN)))
                            cnt_d[k*CW +: CW] = cnt_q[k*CW +: CW] + CW'(1);
                    end
                    if (beat_q == CW'(STREAM_LEN - 1))
                        state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == RUN);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            beat_q      <= '0;
            cnt_q       <= '0;
            z_bits_q    <= '0;
            z_valid_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            z_bits_q    <= z_bits_d;
            z_valid_q   <= z_valid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign z_bits    = z_bits_q;
    assign z_valid   = z_valid_q;
    assign out_count = cnt_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sc_gauss_blur_acc.sv
// Randomised bench for sc_gauss_blur_acc against a per-beat tap-select reference model.
module tb_sc_gauss_blur_acc;
    localparam int NOUT = 2;
    localparam int SL   = 256;
    localparam int W    = NOUT + 2;
    localparam int NB   = 3 * W;
    localparam int CW   = $clog2(SL + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [NB-1:0]     pix_bits;
    logic [NOUT-1:0]   z_bits;
    logic              z_valid;
    logic [NOUT*CW-1:0] out_count;
    logic              out_valid;
    logic              out_ready;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]      m_lfsr;
    int              m_cnt [NOUT];
    int              m_beats;
    int              m_s12;
    int              m_s67;
    logic [NOUT-1:0] m_z;

    sc_gauss_blur_acc #(.NOUT(NOUT), .STREAM_LEN(SL), .SEED(8'h5A)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .pix_bits(pix_bits), .z_bits(z_bits), .z_valid(z_valid),
        .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
    endfunction

    // Window index of the tap picked by select s for output pixel k.
    function automatic int tap_index(input int s, input int k);
        int r, c;
        if (s >= 12)      begin r = 1; c = 1; end
        else if (s >= 10) begin r = 2; c = 1; end
        else if (s >= 8)  begin r = 1; c = 2; end
        else if (s >= 6)  begin r = 1; c = 0; end
        else if (s >= 4)  begin r = 0; c = 1; end
        else              begin r = (s / 2) * 2; c = (s % 2) * 2; end
        return r * W + k + c;
    endfunction

    function automatic int dut_count(input int k);
        return int'(out_count[k*CW +: CW]);
    endfunction

    task automatic check_counts(input string tag);
        for (int k = 0; k < NOUT; k++) begin
            n_cmp++;
            if (dut_count(k) !== m_cnt[k]) begin
                n_err++;
                $display("FAIL %s count%0d: got %0d expected %0d", tag, k, dut_count(k), m_cnt[k]);
            end
        end
    endtask

    // mode: 0 all ones, 1 all zeros, 2 centre tap of pixel 0, 3 random
    task automatic run_frame(input int mode, input bit stall, input bit noise, input int abort_at);
        int cyc, stalls, s;
        bit v;
        logic [NB-1:0] pix;
        logic [NOUT-1:0] exp_z;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; stalls = 0;
        m_lfsr = 8'h5A; m_beats = 0; m_s12 = 0; m_s67 = 0;
        for (int k = 0; k < NOUT; k++) m_cnt[k] = 0;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL start_in_ready: got %b expected 1", in_ready); end
        while (m_beats < SL && cyc < 4000) begin
            v = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            case (mode)
                0: pix = '1;
                1: pix = '0;
                2: pix = NB'(1) << (1 * W + 1);
                default: pix = NB'($urandom);
            endcase
            in_valid = v;
            pix_bits = pix;
            start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (v) begin
                s = int'(m_lfsr[3:0]);
                for (int k = 0; k < NOUT; k++) begin
                    exp_z[k] = pix[tap_index(s, k)];
                    m_cnt[k] += int'(exp_z[k]);
                end
                if (s >= 12) m_s12++;
                if (s == 6 || s == 7) m_s67++;
                m_lfsr = lfsr_next(m_lfsr);
                m_beats++;
                m_z = exp_z;
                n_cmp++;
                if (z_valid !== 1'b1 || z_bits !== exp_z) begin
                    n_err++;
                    $display("FAIL beat%0d_z: got v=%b z=%b expected v=1 z=%b", m_beats, z_valid, z_bits, exp_z);
                end
            end else begin
                stalls++;
                n_cmp++;
                if (z_valid !== 1'b0 || z_bits !== m_z) begin
                    n_err++;
                    $display("FAIL stall_z: got v=%b z=%b expected v=0 z=%b", z_valid, z_bits, m_z);
                end
            end
            if (m_beats == abort_at) begin
                in_valid = 1'b0; start = 1'b0;
                return;
            end
            if (m_beats < SL) begin
                n_cmp++;
                if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL run_flags: got rdy=%b ov=%b expected rdy=1 ov=0", in_ready, out_valid);
                end
            end
        end
        in_valid = 1'b0; start = 1'b0;
        if (cyc >= 4000) begin
            n_err++;
            $display("FAIL frame_timeout: got %0d beats expected %0d", m_beats, SL);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL done_flags: got ov=%b rdy=%b expected ov=1 rdy=0", out_valid, in_ready);
        end
        n_cmp++;
        if (cyc != SL + 1 + stalls) begin
            n_err++;
            $display("FAIL latency: got %0d cycles expected %0d", cyc, SL + 1 + stalls);
        end
        check_counts("frame");
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL release: got ov=%b rdy=%b expected ov=0 rdy=0", out_valid, in_ready);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (in_ready !== 1'b0 || z_valid !== 1'b0 || z_bits !== '0 || out_valid !== 1'b0 || out_count !== '0) begin
            n_err++;
            $display("FAIL %s: got rdy=%b zv=%b z=%b ov=%b cnt=%h expected all zero",
                     tag, in_ready, z_valid, z_bits, out_valid, out_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; pix_bits = '0; out_ready = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_z = '0;
        check_reset_outputs("reset_release");
        in_valid = 1'b1; pix_bits = '1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_reset_outputs("idle_ignores_valid");
    endtask

    task automatic test_all_ones();
        run_frame(0, 1'b0, 1'b0, -1);
        for (int k = 0; k < NOUT; k++) begin
            n_cmp++;
            if (dut_count(k) !== SL) begin
                n_err++;
                $display("FAIL ones_count%0d: got %0d expected %0d", k, dut_count(k), SL);
            end
        end
        release_result();
    endtask

    task automatic test_all_zeros();
        run_frame(1, 1'b0, 1'b0, -1);
        for (int k = 0; k < NOUT; k++) begin
            n_cmp++;
            if (dut_count(k) !== 0) begin
                n_err++;
                $display("FAIL zeros_count%0d: got %0d expected 0", k, dut_count(k));
            end
        end
        release_result();
    endtask

    task automatic test_centre_tap();
        run_frame(2, 1'b0, 1'b0, -1);
        n_cmp++;
        if (dut_count(0) !== m_s12) begin
            n_err++;
            $display("FAIL centre_count0: got %0d expected %0d", dut_count(0), m_s12);
        end
        n_cmp++;
        if (dut_count(1) !== m_s67) begin
            n_err++;
            $display("FAIL centre_count1: got %0d expected %0d", dut_count(1), m_s67);
        end
        release_result();
    endtask

    task automatic test_random_stall();
        for (int f = 0; f < 2; f++) begin
            run_frame(3, 1'b1, 1'b1, -1);
            release_result();
        end
    endtask

    task automatic test_done_hold();
        run_frame(3, 1'b1, 1'b0, -1);
        for (int i = 0; i < 10; i++) begin
            in_valid = $urandom_range(0, 1) == 1;
            pix_bits = NB'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || z_valid !== 1'b0) begin
                n_err++;
                $display("FAIL hold_flags: got ov=%b rdy=%b zv=%b expected 1 0 0", out_valid, in_ready, z_valid);
            end
            check_counts("hold");
        end
        in_valid = 1'b0;
        release_result();
    endtask

    task automatic test_reset_mid_run();
        run_frame(3, 1'b0, 1'b0, 100);
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_run");
        @(posedge clk); #1;
        rst = 1'b0;
        m_z = '0;
        check_reset_outputs("reset_mid_release");
        run_frame(3, 1'b1, 1'b0, -1);
        release_result();
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_centre_tap();
        test_random_stall();
        test_done_hold();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
